axi_write_arbiter: RTL and testbench
====================================

# axi_write_arbiter

Shares one AXI write port (AW, W, B channels) between MASTER_NUM requesters. It sits between the cores' write-side AXI masters and the single shared write slave, such as the memory controller or interconnect port. AW requests are granted round-robin and tagged with the master index in the upper ID bits. W bursts are forwarded in AW-grant order through an outstanding FIFO, and B responses are routed back by ID.

## Interface
- ADDR_WIDTH, 32, AW address width
- DATA_WIDTH, 32, W data width; strobe width DATA_WIDTH/8
- ID_WIDTH, 4, master-side ID width
- MASTER_NUM, 2, number of requesters; must be ≥ 2
- OUTSTANDING, 4, W-order FIFO depth; power of two, ≥ 2
- Derived: IDX_W = $clog2(MASTER_NUM); slave-side ID width = ID_WIDTH+IDX_W
- ACLK  in  1  single clock, rising edge
- ARESETn  in  1  asynchronous active-low reset
- s_awid/s_awaddr/s_awlen  in  [MASTER_NUM] × ID_WIDTH/ADDR_WIDTH/8  per-master AW payload
- s_awvalid  in  MASTER_NUM;  s_awready  out  MASTER_NUM
- s_wdata/s_wstrb/s_wlast  in  [MASTER_NUM] × DATA_WIDTH/DATA_WIDTH/8/1  per-master W payload
- s_wvalid  in  MASTER_NUM;  s_wready  out  MASTER_NUM
- s_bid/s_bresp  out  [MASTER_NUM] × ID_WIDTH/2;  s_bvalid  out  MASTER_NUM;  s_bready  in  MASTER_NUM
- m_awid  out  ID_WIDTH+IDX_W;  m_awaddr  out  ADDR_WIDTH;  m_awlen  out  8;  m_awvalid  out  1;  m_awready  in  1
- m_wdata  out  DATA_WIDTH;  m_wstrb  out  DATA_WIDTH/8;  m_wlast  out  1;  m_wvalid  out  1;  m_wready  in  1
- m_bid  in  ID_WIDTH+IDX_W;  m_bresp  in  2;  m_bvalid  in  1;  m_bready  out  1

## Operation
**AW FSM: AW_IDLE and AW_SEND.** Registered `grant` (IDX_W bits) and `last_grant`.
- AW_IDLE: if FIFO not full and any s_awvalid, load `grant` and go to AW_SEND.
  - The winner is the first valid index scanning `last_grant+1`, `last_grant+2`, … modulo MASTER_NUM (wrap-around).
  - If FIFO is full, no grant is made and the FSM stays in AW_IDLE.
- AW_SEND:
  - m_awvalid = s_awvalid[grant]; m_awaddr/m_awlen = master's payload.
  - m_awid = {grant, s_awid[grant]}.
  - s_awready[grant] = m_awready; all other s_awready = 0.
  - On handshake: push `grant` into FIFO, set `last_grant <= grant`, go to AW_IDLE.
  - `grant` never changes while in AW_SEND, so the payload stays stable while stalled.

**W path.** Combinational, selected by FIFO head `h`.
- With FIFO non-empty:
  - m_wvalid = s_wvalid[h]; m_wdata/m_wstrb/m_wlast = master h's W signals.
  - s_wready[h] = m_wready.
- With FIFO empty: m_wvalid = 0 and all s_wready = 0.
- A W handshake with m_wlast = 1 pops the FIFO.
- Non-head masters are stalled, with s_wready = 0.

**FIFO.** Depth OUTSTANDING, entry width IDX_W, with read/write pointers and a count.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Overflow cannot occur, because a grant is only made when the FIFO is not full, and the count can only fall while in AW_SEND.

**B path.** Combinational, with `bi` = m_bid[ID_WIDTH+IDX_W-1:ID_WIDTH].
- If bi < MASTER_NUM:
  - s_bvalid[bi] = m_bvalid; m_bready = s_bready[bi].
  - s_bid[*] = m_bid[ID_WIDTH-1:0]; s_bresp[*] = m_bresp, broadcast to all masters.
- If bi ≥ MASTER_NUM (only possible when MASTER_NUM is not a power of two): m_bready = 1, all s_bvalid = 0, and the response is dropped.

**Reset (asynchronous assert, state takes effect immediately):**
- FSM = AW_IDLE; `grant` = 0; `last_grant` = MASTER_NUM-1, so master 0 wins first; FIFO empty.
- Resulting outputs: m_awvalid = 0, s_awready = 0, m_wvalid = 0, s_wready = 0.
- B outputs follow m_bvalid combinationally; the slave must also be in reset.
- Any transaction in flight when reset is asserted is abandoned; nothing is replayed.

## Timing
- AW latency: s_awvalid rising in cycle N gives m_awvalid in cycle N+1 (earliest).
- AW throughput: the AW_IDLE step costs one bubble, so at most one AW every 2 cycles.
- W: zero-cycle combinational path, one beat per cycle.
  - The first beat of a burst is forwarded no earlier than the cycle after its AW handshake, when the FIFO push becomes visible.
  - A burst's last beat and the next burst's first beat may be on consecutive cycles.
- B: zero-cycle combinational path, full throughput.
- All combinational paths are valid/ready/data muxes only; there is no combinational path from m_awready to m_awvalid.

## Test plan
- **Reset and first grant:** hold ARESETn = 0, then release; masters 0 and 1 both assert AW. Required: master 0 is granted first (m_awid = {0, id}) and master 1 next; m_awvalid = 0 throughout reset.
- **Round-robin fairness:** MASTER_NUM = 4, all four keep AW valid, m_awready = 1. Required: grant order 0, 1, 2, 3, 0; one AW every 2 cycles.
- **W ordering:** master 1 AW (awlen = 3) is granted, then master 0 AW (awlen = 1); both present W early. Required: 4 master-1 beats with wlast on beat 4, then 2 master-0 beats; master 0 sees s_wready = 0 until master 1's wlast.
- **FIFO full:** OUTSTANDING = 4, m_wready = 0, 5 AWs offered. Required: 4 are accepted and the 5th is not granted until the first wlast pops the FIFO.
- **AW stall stability:** hold m_awready = 0 for 5 cycles in AW_SEND while another master raises awvalid. Required: m_awid/m_awaddr/m_awlen are unchanged and the grant is unchanged.
- **B routing:** MASTER_NUM = 3, m_bid = {2'd1, 4'h5}, then {2'd3, 4'h0}. Required: first goes to s_bvalid[1] with s_bid = 5; second is absorbed with m_bready = 1 and no s_bvalid.

Source files
------------

// File: rtl/axi_write_arbiter_if.sv
// Signal bundle for axi_write_arbiter: per-requester AXI write ports (s_*) and the shared port (m_*).
// The master modport is the arbiter's view (it masters the shared port); slave is the environment's view.
interface axi_write_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int MASTER_NUM = 2
);
  localparam int IDX_W = $clog2(MASTER_NUM);

  logic [MASTER_NUM-1:0][ID_WIDTH-1:0]     s_awid;
  logic [MASTER_NUM-1:0][ADDR_WIDTH-1:0]   s_awaddr;
  logic [MASTER_NUM-1:0][7:0]              s_awlen;
  logic [MASTER_NUM-1:0]                   s_awvalid;
  logic [MASTER_NUM-1:0]                   s_awready;
  logic [MASTER_NUM-1:0][DATA_WIDTH-1:0]   s_wdata;
  logic [MASTER_NUM-1:0][DATA_WIDTH/8-1:0] s_wstrb;
  logic [MASTER_NUM-1:0]                   s_wlast;
  logic [MASTER_NUM-1:0]                   s_wvalid;
  logic [MASTER_NUM-1:0]                   s_wready;
  logic [MASTER_NUM-1:0][ID_WIDTH-1:0]     s_bid;
  logic [MASTER_NUM-1:0][1:0]              s_bresp;
  logic [MASTER_NUM-1:0]                   s_bvalid;
  logic [MASTER_NUM-1:0]                   s_bready;

  logic [ID_WIDTH+IDX_W-1:0] m_awid;
  logic [ADDR_WIDTH-1:0]     m_awaddr;
  logic [7:0]                m_awlen;
  logic                      m_awvalid;
  logic                      m_awready;
  logic [DATA_WIDTH-1:0]     m_wdata;
  logic [DATA_WIDTH/8-1:0]   m_wstrb;
  logic                      m_wlast;
  logic                      m_wvalid;
  logic                      m_wready;
  logic [ID_WIDTH+IDX_W-1:0] m_bid;
  logic [1:0]                m_bresp;
  logic                      m_bvalid;
  logic                      m_bready;

  modport master (
    input  s_awid, s_awaddr, s_awlen, s_awvalid, s_wdata, s_wstrb, s_wlast, s_wvalid, s_bready,
    output s_awready, s_wready, s_bid, s_bresp, s_bvalid,
    output m_awid, m_awaddr, m_awlen, m_awvalid, m_wdata, m_wstrb, m_wlast, m_wvalid, m_bready,
    input  m_awready, m_wready, m_bid, m_bresp, m_bvalid
  );

  modport slave (
    output s_awid, s_awaddr, s_awlen, s_awvalid, s_wdata, s_wstrb, s_wlast, s_wvalid, s_bready,
    input  s_awready, s_wready, s_bid, s_bresp, s_bvalid,
    input  m_awid, m_awaddr, m_awlen, m_awvalid, m_wdata, m_wstrb, m_wlast, m_wvalid, m_bready,
    output m_awready, m_wready, m_bid, m_bresp, m_bvalid
  );
endinterface

// File: rtl/axi_write_arbiter.sv
// Round-robin sharing of one AXI write port among MASTER_NUM requesters; AW grants are tagged
// into the upper ID bits, W follows grant order through a small FIFO, B is routed back by ID.
//
// state   | meaning
// AW_IDLE | no grant held; pick the next requester once the W-order FIFO has room
// AW_SEND | granted master's AW is forwarded until the shared slave accepts it
module axi_write_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int ID_WIDTH    = 4,
  parameter int MASTER_NUM  = 2,
  parameter int OUTSTANDING = 4
) (
  input logic                 ACLK,
  input logic                 ARESETn,
  axi_write_arbiter_if.master bus
);
  localparam int IDX_W = $clog2(MASTER_NUM);
  localparam int PTR_W = $clog2(OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {AW_IDLE, AW_SEND} aw_state_t;

  aw_state_t        aw_state, aw_state_nxt;
  logic [IDX_W-1:0] grant, grant_nxt;
  logic [IDX_W-1:0] last_grant, last_grant_nxt;
  logic [IDX_W-1:0] rr_winner;
  logic             rr_found;
  int               rr_idx;
  logic             aw_push;

  logic [IDX_W-1:0] fifo_mem [OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] fifo_cnt;
  logic             fifo_full, fifo_empty;
  logic [IDX_W-1:0] w_head;
  logic             w_pop;
  logic [IDX_W-1:0] b_idx;

  assign fifo_full  = (fifo_cnt == CNT_W'(OUTSTANDING));
  assign fifo_empty = (fifo_cnt == '0);
  assign w_head     = fifo_mem[rd_ptr];
  assign b_idx      = bus.m_bid[ID_WIDTH+IDX_W-1:ID_WIDTH];

  // Scan begins just past the previous winner, so each requester waits at most MASTER_NUM-1 grants.
  always_comb begin
    rr_winner = '0;
    rr_found  = 1'b0;
    rr_idx    = 0;
    for (int i = 1; i <= MASTER_NUM; i++) begin
      rr_idx = (int'(last_grant) + i) % MASTER_NUM;
      if (!rr_found && bus.s_awvalid[rr_idx]) begin
        rr_found  = 1'b1;
        rr_winner = IDX_W'(rr_idx);
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      aw_state   <= AW_IDLE;
      grant      <= '0;
      last_grant <= IDX_W'(MASTER_NUM - 1);
    end else begin
      aw_state   <= aw_state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  always_comb begin
    aw_state_nxt   = aw_state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    aw_push        = 1'b0;
    bus.m_awvalid  = 1'b0;
    bus.s_awready  = '0;
    bus.m_awid     = {grant, bus.s_awid[grant]};
    bus.m_awaddr   = bus.s_awaddr[grant];
    bus.m_awlen    = bus.s_awlen[grant];
    case (aw_state)
      AW_IDLE: begin
        if (!fifo_full && rr_found) begin
          grant_nxt    = rr_winner;
          aw_state_nxt = AW_SEND;
        end
      end
      AW_SEND: begin
        bus.m_awvalid        = bus.s_awvalid[grant];
        bus.s_awready[grant] = bus.m_awready;
        if (bus.s_awvalid[grant] && bus.m_awready) begin
          aw_push        = 1'b1;
          last_grant_nxt = grant;
          aw_state_nxt   = AW_IDLE;
        end
      end
      default: aw_state_nxt = AW_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int i = 0; i < OUTSTANDING; i++) fifo_mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (aw_push) begin
        fifo_mem[wr_ptr] <= grant;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (w_pop) rd_ptr <= rd_ptr + 1'b1;
      if (aw_push && !w_pop)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (!aw_push && w_pop) fifo_cnt <= fifo_cnt - 1'b1;
    end
  end

  always_comb begin
    bus.m_wvalid = 1'b0;
    bus.m_wdata  = bus.s_wdata[w_head];
    bus.m_wstrb  = bus.s_wstrb[w_head];
    bus.m_wlast  = bus.s_wlast[w_head];
    bus.s_wready = '0;
    w_pop        = 1'b0;
    if (!fifo_empty) begin
      bus.m_wvalid          = bus.s_wvalid[w_head];
      bus.s_wready[w_head]  = bus.m_wready;
      w_pop = bus.s_wvalid[w_head] & bus.m_wready & bus.s_wlast[w_head];
    end
  end

  // Tags beyond MASTER_NUM-1 have no owner; accept and drop them so the slave never hangs.
  always_comb begin
    bus.s_bvalid = '0;
    bus.m_bready = 1'b1;
    for (int i = 0; i < MASTER_NUM; i++) begin
      bus.s_bid[i]   = bus.m_bid[ID_WIDTH-1:0];
      bus.s_bresp[i] = bus.m_bresp;
    end
    if (int'(b_idx) < MASTER_NUM) begin
      bus.s_bvalid[b_idx] = bus.m_bvalid;
      bus.m_bready        = bus.s_bready[b_idx];
    end
  end
endmodule

// File: tb/tb_axi_write_arbiter.sv
// Directed bench for axi_write_arbiter (3 masters, so the unowned-ID B drop is reachable);
// a transaction-level model is compared against the DUT every cycle on the falling edge.
module tb_axi_write_arbiter;
  localparam int P_AW  = 32;
  localparam int P_DW  = 32;
  localparam int P_IW  = 4;
  localparam int MN    = 3;
  localparam int OS    = 4;
  localparam int IDX   = 2;

  typedef struct packed {logic [3:0] id; logic [31:0] addr; logic [7:0] len;} aw_t;
  typedef struct packed {logic [31:0] data; logic [3:0] strb; logic last;} w_t;

  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  always #5 ACLK = ~ACLK;

  axi_write_arbiter_if #(.ADDR_WIDTH(P_AW), .DATA_WIDTH(P_DW), .ID_WIDTH(P_IW), .MASTER_NUM(MN)) bus();

  axi_write_arbiter #(
    .ADDR_WIDTH(P_AW), .DATA_WIDTH(P_DW), .ID_WIDTH(P_IW), .MASTER_NUM(MN), .OUTSTANDING(OS)
  ) dut (
    .ACLK(ACLK),
    .ARESETn(ARESETn),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  aw_t aw_q [MN][$];
  w_t  w_q  [MN][$];
  logic [MN-1:0] aw_hs_m = '0;
  logic [MN-1:0] w_hs_m = '0;

  // Model: the master currently holding the AW grant (-1 = none), last winner, W-order queue.
  int owner = -1;
  int last = MN - 1;
  int wq[$];

  int aw_log_m[$];
  logic [5:0] aw_log_id[$];
  int aw_log_t[$];
  int w_log_m[$];
  logic w_log_last[$];
  int w_log_t[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge ACLK) begin
    logic [MN-1:0] e_awready, e_wready, e_bvalid;
    logic e_awvalid, e_wvalid, e_bready, aw_fire, w_fire_last;
    int h, bi, occ;
    cyc++;

    e_awvalid = (owner >= 0) ? bus.s_awvalid[owner] : 1'b0;
    e_awready = '0;
    if (owner >= 0) e_awready[owner] = bus.m_awready;
    chk("m_awvalid", bus.m_awvalid, e_awvalid);
    chk("s_awready", bus.s_awready, e_awready);
    if (e_awvalid) begin
      chk("m_awid", bus.m_awid, {IDX'(owner), bus.s_awid[owner]});
      chk("m_awaddr", bus.m_awaddr, bus.s_awaddr[owner]);
      chk("m_awlen", bus.m_awlen, bus.s_awlen[owner]);
    end

    e_wvalid = 1'b0;
    e_wready = '0;
    h = (wq.size() > 0) ? wq[0] : -1;
    if (h >= 0) begin
      e_wvalid = bus.s_wvalid[h];
      e_wready[h] = bus.m_wready;
    end
    chk("m_wvalid", bus.m_wvalid, e_wvalid);
    chk("s_wready", bus.s_wready, e_wready);
    if (e_wvalid) begin
      chk("m_wdata", bus.m_wdata, bus.s_wdata[h]);
      chk("m_wstrb", bus.m_wstrb, bus.s_wstrb[h]);
      chk("m_wlast", bus.m_wlast, bus.s_wlast[h]);
    end

    bi = int'(bus.m_bid[P_IW+IDX-1:P_IW]);
    e_bvalid = '0;
    e_bready = 1'b1;
    if (bi < MN) begin
      e_bvalid[bi] = bus.m_bvalid;
      e_bready = bus.s_bready[bi];
    end
    chk("s_bvalid", bus.s_bvalid, e_bvalid);
    chk("m_bready", bus.m_bready, e_bready);
    if (bus.m_bvalid) begin
      for (int i = 0; i < MN; i++) begin
        chk("s_bid", bus.s_bid[i], bus.m_bid[P_IW-1:0]);
        chk("s_bresp", bus.s_bresp[i], bus.m_bresp);
      end
    end

    if (bus.m_awvalid && bus.m_awready) begin
      aw_log_m.push_back(int'(bus.m_awid[P_IW+IDX-1:P_IW]));
      aw_log_id.push_back(bus.m_awid);
      aw_log_t.push_back(cyc);
    end
    if (bus.m_wvalid && bus.m_wready) begin
      w_log_m.push_back(int'(bus.m_wdata[31:28]) - 1);
      w_log_last.push_back(bus.m_wlast);
      w_log_t.push_back(cyc);
    end
    for (int i = 0; i < MN; i++) begin
      aw_hs_m[i] = bus.s_awvalid[i] && bus.s_awready[i];
      w_hs_m[i]  = bus.s_wvalid[i] && bus.s_wready[i];
    end

    // Advance the model to the state after the coming rising edge.
    if (!ARESETn) begin
      owner = -1;
      last = MN - 1;
      wq.delete();
    end else begin
      occ = wq.size();
      aw_fire = (owner >= 0) && e_awvalid && bus.m_awready;
      w_fire_last = (h >= 0) && bus.s_wvalid[h] && bus.m_wready && bus.s_wlast[h];
      if (w_fire_last) void'(wq.pop_front());
      if (owner < 0) begin
        if (occ < OS) begin
          for (int k = 1; k <= MN; k++)
            if (owner < 0 && bus.s_awvalid[(last + k) % MN]) owner = (last + k) % MN;
        end
      end else if (aw_fire) begin
        wq.push_back(owner);
        last = owner;
        owner = -1;
      end
    end
  end

  initial begin
    bus.s_awvalid = '0; bus.s_awid = '0; bus.s_awaddr = '0; bus.s_awlen = '0;
    bus.s_wvalid = '0;  bus.s_wdata = '0; bus.s_wstrb = '0;  bus.s_wlast = '0;
    forever begin
      @(posedge ACLK);
      #1;
      for (int i = 0; i < MN; i++) begin
        if (aw_hs_m[i] && aw_q[i].size() > 0) void'(aw_q[i].pop_front());
        if (w_hs_m[i] && w_q[i].size() > 0) void'(w_q[i].pop_front());
        bus.s_awvalid[i] = (aw_q[i].size() > 0);
        if (aw_q[i].size() > 0) begin
          bus.s_awid[i]   = aw_q[i][0].id;
          bus.s_awaddr[i] = aw_q[i][0].addr;
          bus.s_awlen[i]  = aw_q[i][0].len;
        end
        bus.s_wvalid[i] = (w_q[i].size() > 0);
        if (w_q[i].size() > 0) begin
          bus.s_wdata[i] = w_q[i][0].data;
          bus.s_wstrb[i] = w_q[i][0].strb;
          bus.s_wlast[i] = w_q[i][0].last;
        end
      end
    end
  end

  task automatic tick();
    @(posedge ACLK);
    #2;
  endtask

  task automatic push_aw(input int m, input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
    aw_t t;
    t.id = id; t.addr = addr; t.len = len;
    aw_q[m].push_back(t);
  endtask

  task automatic push_w(input int m, input int n);
    w_t b;
    for (int k = 0; k < n; k++) begin
      b.data = {4'(m + 1), 28'(k)};
      b.strb = 4'(k + 1);
      b.last = (k == n - 1);
      w_q[m].push_back(b);
    end
  endtask

  function automatic int pending();
    int p = 0;
    for (int i = 0; i < MN; i++) p += aw_q[i].size() + w_q[i].size();
    return p;
  endfunction

  task automatic wait_aw(input int n, input int budget, input string name);
    int k = 0;
    while (aw_log_m.size() < n && k < budget) begin tick(); k++; end
    chk(name, aw_log_m.size(), n);
  endtask

  task automatic drain(input string name);
    int k = 0;
    while (pending() != 0 && k < 200) begin tick(); k++; end
    repeat (3) tick();
    chk(name, pending(), 0);
  endtask

  task automatic clear_logs();
    aw_log_m.delete(); aw_log_id.delete(); aw_log_t.delete();
    w_log_m.delete(); w_log_last.delete(); w_log_t.delete();
  endtask

  initial begin
    int exp2 [6] = '{2, 0, 1, 2, 0, 1};
    int exp3m [6] = '{1, 1, 1, 1, 0, 0};
    int exp3l [6] = '{0, 0, 0, 1, 0, 1};
    int exp4 [4] = '{1, 2, 0, 1};
    int k;

    bus.m_awready = 1'b1; bus.m_wready = 1'b1;
    bus.m_bvalid = 1'b0; bus.m_bid = '0; bus.m_bresp = '0;
    bus.s_bready = '0;

    // Reset and first grant: masters 0 and 1 request while reset is held.
    push_aw(0, 4'hA, 32'h0000_0100, 8'd0); push_w(0, 1);
    push_aw(1, 4'hB, 32'h0000_0200, 8'd0); push_w(1, 1);
    repeat (4) begin
      tick();
      chk("rst_m_awvalid", bus.m_awvalid, 0);
      chk("rst_s_awready", bus.s_awready, 0);
      chk("rst_m_wvalid", bus.m_wvalid, 0);
      chk("rst_s_wready", bus.s_wready, 0);
    end
    ARESETn = 1'b1;
    wait_aw(2, 20, "t1_aw_count");
    chk("t1_first_id", aw_log_id[0], 6'h0A);
    chk("t1_second_id", aw_log_id[1], 6'h1B);
    chk("t1_gap", aw_log_t[1] - aw_log_t[0], 2);
    drain("t1_drain");

    // Round-robin: every master keeps AW valid; last winner was 1, so 2 goes first.
    clear_logs();
    for (int m = 0; m < MN; m++) begin
      push_aw(m, 4'(m), 32'h1000 * (m + 1), 8'd0);
      push_aw(m, 4'(m + 8), 32'h1000 * (m + 1) + 32'h40, 8'd0);
      push_w(m, 1); push_w(m, 1);
    end
    wait_aw(6, 40, "t2_aw_count");
    for (int i = 0; i < 6; i++) chk("t2_order", aw_log_m[i], exp2[i]);
    for (int i = 0; i < 5; i++) chk("t2_gap", aw_log_t[i + 1] - aw_log_t[i], 2);
    drain("t2_drain");

    // W ordering: master 1 burst of 4, then master 0 burst of 2, both W presented early.
    clear_logs();
    push_aw(1, 4'h1, 32'h2000, 8'd3); push_w(1, 4); push_w(0, 2);
    wait_aw(1, 20, "t3_first_aw");
    push_aw(0, 4'h2, 32'h3000, 8'd1);
    drain("t3_drain");
    chk("t3_beats", w_log_m.size(), 6);
    for (int i = 0; i < 6; i++) begin
      chk("t3_w_master", w_log_m[i], exp3m[i]);
      chk("t3_w_last", w_log_last[i], exp3l[i]);
    end

    // FIFO full: W stalled, five AWs offered, only four accepted until a wlast pops.
    clear_logs();
    bus.m_wready = 1'b0;
    push_aw(0, 4'h4, 32'h4000, 8'd0); push_aw(0, 4'h5, 32'h4100, 8'd0);
    push_aw(1, 4'h6, 32'h5000, 8'd0); push_aw(1, 4'h7, 32'h5100, 8'd0);
    push_aw(2, 4'h8, 32'h6000, 8'd0);
    push_w(0, 1); push_w(0, 1); push_w(1, 1); push_w(1, 1); push_w(2, 1);
    wait_aw(4, 40, "t4_four_accepted");
    repeat (8) tick();
    chk("t4_fifth_held", aw_log_m.size(), 4);
    chk("t4_idle_awvalid", bus.m_awvalid, 0);
    for (int i = 0; i < 4; i++) chk("t4_order", aw_log_m[i], exp4[i]);
    bus.m_wready = 1'b1;
    wait_aw(5, 20, "t4_fifth_accepted");
    chk("t4_fifth_master", aw_log_m[4], 0);
    chk("t4_after_pop", aw_log_t[4] > w_log_t[0], 1);
    drain("t4_drain");

    // AW stall: payload and grant hold while another master raises awvalid.
    clear_logs();
    bus.m_awready = 1'b0;
    push_aw(1, 4'h3, 32'hDEAD_0000, 8'd7); push_w(1, 8);
    k = 0;
    while (!bus.m_awvalid && k < 10) begin tick(); k++; end
    chk("t5_awvalid_seen", bus.m_awvalid, 1);
    push_aw(0, 4'h6, 32'h0000_0600, 8'd0); push_w(0, 1);
    repeat (5) begin
      tick();
      chk("t5_awvalid", bus.m_awvalid, 1);
      chk("t5_awid", bus.m_awid, 6'h13);
      chk("t5_awaddr", bus.m_awaddr, 32'hDEAD_0000);
      chk("t5_awlen", bus.m_awlen, 8'd7);
    end
    bus.m_awready = 1'b1;
    wait_aw(2, 20, "t5_aw_count");
    chk("t5_first", aw_log_m[0], 1);
    chk("t5_second", aw_log_m[1], 0);
    drain("t5_drain");

    // B routing, including an ID tag with no owning master.
    bus.m_bvalid = 1'b1; bus.m_bid = 6'h15; bus.m_bresp = 2'b10; bus.s_bready = 3'b010;
    tick();
    chk("t6_bvalid_m1", bus.s_bvalid, 3'b010);
    chk("t6_bid_m1", bus.s_bid[1], 4'h5);
    chk("t6_bresp_m1", bus.s_bresp[1], 2'b10);
    chk("t6_bready_m1", bus.m_bready, 1);
    bus.s_bready = 3'b101;
    tick();
    chk("t6_bready_blocked", bus.m_bready, 0);
    bus.m_bid = 6'h30;
    tick();
    chk("t6_drop_bvalid", bus.s_bvalid, 3'b000);
    chk("t6_drop_bready", bus.m_bready, 1);
    bus.m_bid = 6'h2C; bus.s_bready = 3'b100;
    tick();
    chk("t6_bvalid_m2", bus.s_bvalid, 3'b100);
    chk("t6_bid_broadcast", bus.s_bid[0], 4'hC);
    chk("t6_bready_m2", bus.m_bready, 1);
    bus.m_bvalid = 1'b0; bus.s_bready = '0;
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
